// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 32-bit multi-cycle divider.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/div_unit_32_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the final quotient/remainder sign correction.
module div_sign_fix
    import div_pkg::*;
(
    input  logic            i_neg,
    input  logic [XLEN-1:0] i_val,
    output logic [XLEN-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + 32'd1) : i_val;

endmodule

// File: rtl/div_unit_32.sv
// Restoring 32-bit divider (DIV/DIVU/REM/REMU) driving the shared ALU adder.
// Optional DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
module div_unit_32
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            add_req,
    output logic [XLEN-1:0] add_a,
    output logic [XLEN-1:0] add_b,
    output logic            add_cin,
    input  logic [XLEN-1:0] add_sum,
    input  logic            add_cout
);

    div_state_t      r_state;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [4:0]      r_cnt;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_is_rem;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_abs_dvd;
    logic [XLEN-1:0] w_abs_dvs;
    logic            w_div0;
    logic            w_ovf;
    logic            w_early;
    logic [XLEN-1:0] w_rs;
    logic            w_accept;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic            w_in_div;

    assign w_signed  = (op == OP_DIV) || (op == OP_REM);
    assign w_dvd_neg = w_signed & dividend[XLEN-1];
    assign w_dvs_neg = w_signed & divisor[XLEN-1];
    assign w_div0    = (divisor == '0);
    assign w_ovf     = w_signed && (dividend == INT_MIN) && (divisor == DIV0_Q);

    div_sign_fix u_abs_dvd (.i_neg(w_dvd_neg), .i_val(dividend), .o_val(w_abs_dvd));
    div_sign_fix u_abs_dvs (.i_neg(w_dvs_neg), .i_val(divisor),  .o_val(w_abs_dvs));
    div_sign_fix u_fix_quo (.i_neg(r_qneg),    .i_val(r_quo),    .o_val(w_quo_fix));
    div_sign_fix u_fix_rem (.i_neg(r_rneg),    .i_val(r_rem),    .o_val(w_rem_fix));

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_abs_dvd < w_abs_dvs);
`else
    assign w_early = 1'b0;
`endif

    // The adder computes Rs - D; its carry-out means Rs >= D.
    assign w_in_div = (r_state == S_DIV);
    assign w_rs     = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_accept = r_rem[XLEN-1] | add_cout;

    assign add_req = w_in_div;
    assign add_a   = w_in_div ? w_rs : '0;
    assign add_b   = w_in_div ? ~r_dvs : '0;
    assign add_cin = w_in_div;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_rem <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_rem <= op[1];
                        if (w_div0) begin
                            r_result <= op[1] ? dividend : DIV0_Q;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_ovf) begin
                            r_result <= op[1] ? '0 : INT_MIN;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_qneg  <= w_dvd_neg ^ w_dvs_neg;
                            r_rneg  <= w_dvd_neg;
                            r_rem   <= w_early ? w_abs_dvd : '0;
                            r_quo   <= w_early ? '0 : w_abs_dvd;
                            r_dvs   <= w_abs_dvs;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= w_early ? S_FIX : S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (w_accept) begin
                        r_rem <= add_sum;
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rs;
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
